advanced_wrapping_counter: RTL and testbench
============================================

Name: advanced_wrapping_counter

Overview:
Parameterised up/down modulo-RANGE counter with optional lap (wrap-parity) bit, synchronous load, min/max status flags and one-cycle overflow/underflow pulses. Used as a generic building block, e.g. for FIFO/ring-buffer read/write pointers where the lap bit distinguishes full from empty. Single clock domain.

Parameters:
RANGE, 4, number of distinct index values (0..RANGE-1); must be ≥2, need not be a power of 2
RESET_VALUE, 0, index value after reset; must be < RANGE
LAP_BIT, 1, 1 = append lap bit as MSB of count; 0 = no lap bit
Derived localparams: WIDTH_NO_LAP = clog2(RANGE); WIDTH = WIDTH_NO_LAP + LAP_BIT; COUNT_MIN = 0; COUNT_MAX = RANGE-1

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_enable  input  1  load count from load_count this cycle
load_count  input  WIDTH  value to load (index in low bits, lap in MSB if LAP_BIT)
decrement  input  1  step count down by one
increment  input  1  step count up by one
count  output  WIDTH  current count: index in [WIDTH_NO_LAP-1:0], lap bit at [WIDTH-1] when LAP_BIT=1
minimum  output  1  index == COUNT_MIN
maximum  output  1  index == COUNT_MAX
underflow  output  1  registered pulse: previous cycle wrapped MIN->MAX
overflow  output  1  registered pulse: previous cycle wrapped MAX->MIN

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled on rising edge, highest priority): index = RESET_VALUE, lap = 0, overflow = underflow = 0. Applies identically mid-operation.
- Priority per rising edge, after reset: load_enable > increment/decrement.
- Load: index <= load_count index field (values ≥ RANGE saturate to COUNT_MAX); lap <= load_count MSB (if LAP_BIT); overflow/underflow <= 0; increment/decrement ignored.
- increment && !decrement: index == COUNT_MAX -> index <= COUNT_MIN, lap toggles, overflow <= 1; otherwise index+1, lap unchanged.
- decrement && !increment: index == COUNT_MIN -> index <= COUNT_MAX, lap toggles, underflow <= 1; otherwise index-1, lap unchanged.
- Both or neither asserted: count holds, overflow = underflow = 0.
- overflow/underflow are flops: high for exactly the one cycle following the wrapping edge, otherwise 0; never both high.
- minimum/maximum: combinational decodes of the registered index (no added latency); valid immediately after reset.
- count latency: one cycle from input sampling to updated output.
- Non-power-of-2 RANGE: wrap compares against COUNT_MAX explicitly; no reliance on natural binary rollover.
- LAP_BIT=0: count is WIDTH_NO_LAP bits; no lap logic generated.

Decomposition:
- No shared package; derived widths are module localparams.
- Single flat module, no sub-modules; lap bit handled by a generate branch on LAP_BIT.

Test Plan:
- RANGE=4, RESET_VALUE=0, LAP_BIT=1, reset high one cycle -> count=0b000, minimum=1, maximum=0, overflow=underflow=0.
- increment held 3 cycles from 0 -> index 1,2,3; lap stays 0; no pulses; maximum=1 at 3.
- increment at index 3 -> next cycle index 0, lap toggles to 1, overflow=1 for one cycle, minimum=1; then decrement at 0 -> index 3, lap back to 0, underflow=1 for one cycle, maximum=1.
- Full cycles: 4 increments from 0 return to 0 with exactly one overflow and one lap toggle; same with 4 decrements and underflow.
- 1000 cycles of random increment/decrement (p=0.5 each) -> index matches modulo model, both-asserted holds, pulses and lap toggles only on wraps, min/max flags consistent.
- load_enable=1, load_count=3 with increment=1 -> next cycle index 3, maximum=1, minimum=0, no overflow/underflow; reset asserted mid-count -> index 0, lap 0, flags cleared.

Source files
------------

// File: rtl/advanced_wrapping_counter.sv
// Up/down modulo-RANGE counter with optional lap bit, synchronous load and wrap pulses.
// One cycle from sampled inputs to count; min/max decode the registered index directly.
module advanced_wrapping_counter #(
  parameter int RANGE        = 4,
  parameter int RESET_VALUE  = 0,
  parameter int LAP_BIT      = 1,
  localparam int WIDTH_NO_LAP = $clog2(RANGE),
  localparam int WIDTH        = WIDTH_NO_LAP + LAP_BIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_count,
  input  logic             decrement,
  input  logic             increment,
  output logic [WIDTH-1:0] count,
  output logic             minimum,
  output logic             maximum,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [WIDTH_NO_LAP-1:0] COUNT_MIN = '0;
  localparam logic [WIDTH_NO_LAP-1:0] COUNT_MAX = WIDTH_NO_LAP'(RANGE - 1);
  localparam logic [WIDTH_NO_LAP-1:0] RESET_IDX = WIDTH_NO_LAP'(RESET_VALUE);

  logic [WIDTH_NO_LAP-1:0] index_q, index_d;
  logic [WIDTH_NO_LAP-1:0] load_idx;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic                    lap_toggle;

  // Only a non-power-of-2 range has index codes beyond COUNT_MAX to clamp.
  generate
    if (RANGE == (1 << WIDTH_NO_LAP)) begin : g_no_sat
      assign load_idx = load_count[WIDTH_NO_LAP-1:0];
    end else begin : g_sat
      assign load_idx = (load_count[WIDTH_NO_LAP-1:0] > COUNT_MAX) ? COUNT_MAX
                                                                   : load_count[WIDTH_NO_LAP-1:0];
    end
  endgenerate

  always_comb begin
    index_d     = index_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    lap_toggle  = 1'b0;
    if (load_enable) begin
      index_d = load_idx;
    end else if (increment && !decrement) begin
      if (index_q == COUNT_MAX) begin
        index_d    = COUNT_MIN;
        overflow_d = 1'b1;
        lap_toggle = 1'b1;
      end else begin
        index_d = index_q + WIDTH_NO_LAP'(1);
      end
    end else if (decrement && !increment) begin
      if (index_q == COUNT_MIN) begin
        index_d     = COUNT_MAX;
        underflow_d = 1'b1;
        lap_toggle  = 1'b1;
      end else begin
        index_d = index_q - WIDTH_NO_LAP'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index_q     <= RESET_IDX;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      index_q     <= index_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    if (LAP_BIT != 0) begin : g_lap
      logic lap_q, lap_d;

      always_comb begin
        lap_d = lap_q ^ lap_toggle;
        if (load_enable) begin
          lap_d = load_count[WIDTH-1];
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          lap_q <= 1'b0;
        end else begin
          lap_q <= lap_d;
        end
      end

      assign count = {lap_q, index_q};
    end else begin : g_no_lap
      assign count = index_q;
    end
  endgenerate

  assign minimum   = (index_q == COUNT_MIN);
  assign maximum   = (index_q == COUNT_MAX);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_advanced_wrapping_counter.sv
// Scoreboard bench for advanced_wrapping_counter (RANGE=4, RESET_VALUE=0, LAP_BIT=1).
module tb_advanced_wrapping_counter;

  typedef struct packed {
    logic [2:0] cnt;
    logic       mn;
    logic       mx;
    logic       ov;
    logic       un;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_enable = 1'b0;
  logic [2:0] load_count = 3'd0;
  logic       decrement = 1'b0;
  logic       increment = 1'b0;
  logic [2:0] count;
  logic       minimum, maximum, underflow, overflow;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic stim_done = 1'b0;

  advanced_wrapping_counter #(.RANGE(4), .RESET_VALUE(0), .LAP_BIT(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_enable (load_enable),
    .load_count  (load_count),
    .decrement   (decrement),
    .increment   (increment),
    .count       (count),
    .minimum     (minimum),
    .maximum     (maximum),
    .underflow   (underflow),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  function automatic exp_t ex(logic [2:0] c, logic mn, logic mx, logic ov, logic un);
    exp_t e;
    e.cnt = c; e.mn = mn; e.mx = mx; e.ov = ov; e.un = un;
    return e;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: the counter presents a fresh output every cycle, one edge after each stimulus.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count",     {1'b0, count},    {1'b0, e.cnt});
      check("minimum",   {3'b0, minimum},  {3'b0, e.mn});
      check("maximum",   {3'b0, maximum},  {3'b0, e.mx});
      check("overflow",  {3'b0, overflow}, {3'b0, e.ov});
      check("underflow", {3'b0, underflow},{3'b0, e.un});
    end
  end

  task automatic apply(logic rst, logic ld, logic [2:0] lc, logic inc, logic dec, exp_t e);
    @(negedge clock);
    reset       = rst;
    load_enable = ld;
    load_count  = lc;
    increment   = inc;
    decrement   = dec;
    exp_q.push_back(e);
  endtask

  initial begin
    int   m_idx;
    logic m_lap;
    logic inc, dec, ov, un;

    // rst ld lc inc dec | count min max ovf unf
    apply(1, 0, 3'd0, 0, 0, ex(3'b000, 1, 0, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b001, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b010, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b011, 0, 1, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b100, 1, 0, 1, 0));
    apply(0, 0, 3'd0, 0, 1, ex(3'b011, 0, 1, 0, 1));
    apply(0, 0, 3'd0, 0, 0, ex(3'b011, 0, 1, 0, 0));
    apply(0, 0, 3'd0, 1, 1, ex(3'b011, 0, 1, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b100, 1, 0, 1, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b101, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b110, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b111, 0, 1, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b000, 1, 0, 1, 0));
    apply(0, 0, 3'd0, 0, 1, ex(3'b111, 0, 1, 0, 1));
    apply(0, 0, 3'd0, 0, 1, ex(3'b110, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 0, 1, ex(3'b101, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 0, 1, ex(3'b100, 1, 0, 0, 0));
    apply(0, 1, 3'd3, 1, 0, ex(3'b011, 0, 1, 0, 0));
    apply(0, 1, 3'd7, 0, 0, ex(3'b111, 0, 1, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b000, 1, 0, 1, 0));
    apply(0, 1, 3'd2, 0, 1, ex(3'b010, 0, 0, 0, 0));
    apply(0, 0, 3'd0, 1, 0, ex(3'b011, 0, 1, 0, 0));
    apply(1, 0, 3'd0, 1, 0, ex(3'b000, 1, 0, 0, 0));
    apply(0, 0, 3'd0, 0, 1, ex(3'b111, 0, 1, 0, 1));
    apply(1, 1, 3'd2, 0, 1, ex(3'b000, 1, 0, 0, 0));

    // Random walk from the known reset state, checked against a modulo-4 model.
    m_idx = 0;
    m_lap = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      inc = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      ov  = 1'b0;
      un  = 1'b0;
      if (inc && !dec) begin
        if (m_idx == 3) begin m_idx = 0; m_lap = ~m_lap; ov = 1'b1; end
        else m_idx = m_idx + 1;
      end else if (dec && !inc) begin
        if (m_idx == 0) begin m_idx = 3; m_lap = ~m_lap; un = 1'b1; end
        else m_idx = m_idx - 1;
      end
      apply(0, 0, 3'd0, inc, dec,
            ex({m_lap, 2'(m_idx)}, (m_idx == 0), (m_idx == 3), ov, un));
    end

    @(negedge clock);
    increment = 1'b0;
    decrement = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks so far %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
